spi_shift_master: RTL and testbench

SPI_SHIFT_MASTER -- requirements
Module: spi_shift_master

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 25 ++
 rtl/spi_shift_master.sv | 164 ++++++++++++++++
 tb/tb_spi_shift_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and mode encodings for the SPI shift master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

  localparam bit CPOL_IDLE_LOW     = 1'b0;
  localparam bit CPOL_IDLE_HIGH    = 1'b1;
  localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_c marks the last clk cycle of each SCLK half-period.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_c
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

  // Counter restarts whenever the divider is idle so each frame begins on a full half-period.
  always_ff @(posedge clk) begin
    if (reset || !en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_shift_master.sv
// SPI master: one full-duplex DATA_W-bit frame per accepted word, configurable mode and bit order.
module spi_shift_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          CPOL      = CPOL_IDLE_LOW,
  parameter bit          CPHA      = CPHA_SAMPLE_LEAD,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  output logic                        busy,
  output logic [$clog2(DATA_W+1)-1:0] counter,
  output logic                        spi_sclk,
  output logic                        spi_cs_l,
  output logic                        spi_data,
  input  logic                        spi_miso
);
  localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned EDGES    = 2 * DATA_W;
  localparam int unsigned HALF_W   = $clog2(EDGES + 1);
  localparam int unsigned GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned GAP_LAST = (CS_GAP > 0) ? CS_GAP - 1 : 0;

  spi_state_e        state, state_n;
  logic [DATA_W-1:0] tx_sr, tx_sr_n, rx_sr, rx_sr_n, rx_data_n, tx_shift_c;
  logic [HALF_W-1:0] half_cnt, half_cnt_n, edge_num_c;
  logic [CNT_W-1:0]  counter_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic              trail_end, trail_end_n;
  logic              sclk_n, cs_l_n, data_n, rx_valid_n;
  logic              div_en_c, tick_c, edge_odd_c, do_sample_c, do_shift_c;

  assign div_en_c = (state == ST_LEAD) || (state == ST_SHIFT) ||
                    ((state == ST_TRAIL) && !trail_end);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en_c),
    .tick_c(tick_c)
  );

  // Edge classification for the SCLK edge about to be produced (1-based).
  assign edge_num_c  = half_cnt + HALF_W'(1);
  assign edge_odd_c  = edge_num_c[0];
  assign do_sample_c = (CPHA == CPHA_SAMPLE_TRAIL) ? !edge_odd_c : edge_odd_c;
  assign do_shift_c  = (CPHA == CPHA_SAMPLE_TRAIL) ?
                       (edge_odd_c && (edge_num_c != HALF_W'(1))) :
                       (!edge_odd_c && (edge_num_c != HALF_W'(EDGES)));
  assign tx_shift_c  = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};

  always_comb begin
    state_n     = state;
    tx_sr_n     = tx_sr;
    rx_sr_n     = rx_sr;
    rx_data_n   = rx_data;
    half_cnt_n  = half_cnt;
    counter_n   = counter;
    gap_cnt_n   = gap_cnt;
    trail_end_n = trail_end;
    sclk_n      = spi_sclk;
    cs_l_n      = spi_cs_l;
    data_n      = spi_data;
    rx_valid_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_n    = ST_LEAD;
          tx_sr_n    = tx_data;
          rx_sr_n    = '0;
          half_cnt_n = '0;
          counter_n  = '0;
          cs_l_n     = 1'b0;
          data_n     = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
        end
      end
      ST_LEAD, ST_SHIFT: begin
        if (tick_c) begin
          if (half_cnt == HALF_W'(EDGES)) begin
            state_n = ST_TRAIL;
          end else begin
            state_n    = ST_SHIFT;
            sclk_n     = ~spi_sclk;
            half_cnt_n = edge_num_c;
            if (do_sample_c) begin
              rx_sr_n   = MSB_FIRST ? {rx_sr[DATA_W-2:0], spi_miso} :
                                      {spi_miso, rx_sr[DATA_W-1:1]};
              counter_n = counter + CNT_W'(1);
            end
            if (do_shift_c) begin
              tx_sr_n = tx_shift_c;
              data_n  = MSB_FIRST ? tx_shift_c[DATA_W-1] : tx_shift_c[0];
            end
          end
        end
      end
      // TRAIL ends with one extra cycle in which chip select is already released.
      ST_TRAIL: begin
        if (trail_end) begin
          trail_end_n = 1'b0;
          gap_cnt_n   = '0;
          state_n     = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
        end else if (tick_c) begin
          trail_end_n = 1'b1;
          cs_l_n      = 1'b1;
          data_n      = 1'b0;
          rx_valid_n  = 1'b1;
          rx_data_n   = rx_sr;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      half_cnt  <= '0;
      counter   <= '0;
      gap_cnt   <= '0;
      trail_end <= 1'b0;
      spi_sclk  <= CPOL;
      spi_cs_l  <= 1'b1;
      spi_data  <= 1'b0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      tx_sr     <= tx_sr_n;
      rx_sr     <= rx_sr_n;
      rx_data   <= rx_data_n;
      half_cnt  <= half_cnt_n;
      counter   <= counter_n;
      gap_cnt   <= gap_cnt_n;
      trail_end <= trail_end_n;
      spi_sclk  <= sclk_n;
      spi_cs_l  <= cs_l_n;
      spi_data  <= data_n;
      rx_valid  <= rx_valid_n;
      tx_ready  <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spi_shift_master.sv
// Directed bench: mode 0 / 24-bit loopback, mode 3 / 8-bit slave model, LSB-first 8-bit.
module tb_spi_shift_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode 0, 24-bit, CLK_DIV=2, loopback
  logic        r0 = 1'b1, tv0 = 1'b0, trdy0, rxv0, busy0, sclk0, cs0, mosi0;
  logic [23:0] td0 = '0, rxd0;
  logic [4:0]  cnt0;
  spi_shift_master u0 (
    .clk(clk), .reset(r0), .tx_data(td0), .tx_valid(tv0), .tx_ready(trdy0),
    .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0), .counter(cnt0),
    .spi_sclk(sclk0), .spi_cs_l(cs0), .spi_data(mosi0), .spi_miso(mosi0)
  );

  // Mode 3, 8-bit, CLK_DIV=1, external slave
  logic       r3 = 1'b1, tv3 = 1'b0, trdy3, rxv3, busy3, sclk3, cs3, mosi3, miso3 = 1'b0;
  logic [7:0] td3 = '0, rxd3;
  logic [3:0] cnt3;
  spi_shift_master #(.DATA_W(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .clk(clk), .reset(r3), .tx_data(td3), .tx_valid(tv3), .tx_ready(trdy3),
    .rx_data(rxd3), .rx_valid(rxv3), .busy(busy3), .counter(cnt3),
    .spi_sclk(sclk3), .spi_cs_l(cs3), .spi_data(mosi3), .spi_miso(miso3)
  );

  // LSB first, mode 0, 8-bit, CLK_DIV=1, loopback
  logic       rl = 1'b1, tvl = 1'b0, trdyl, rxvl, busyl, sclkl, csl, mosil;
  logic [7:0] tdl = '0, rxdl;
  logic [3:0] cntl;
  spi_shift_master #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) ul (
    .clk(clk), .reset(rl), .tx_data(tdl), .tx_valid(tvl), .tx_ready(trdyl),
    .rx_data(rxdl), .rx_valid(rxvl), .busy(busyl), .counter(cntl),
    .spi_sclk(sclkl), .spi_cs_l(csl), .spi_data(mosil), .spi_miso(mosil)
  );

  // Mode 3 slave: drives MISO after falling SCLK, captures MOSI after rising SCLK.
  logic [7:0] s_word = 8'h3C;
  logic [7:0] s_mosi = '0;
  int         s_out = 0, s_rises = 0;
  logic       ps3 = 1'b1, pc3 = 1'b1;
  always @(negedge clk) begin
    if (pc3 === 1'b1 && cs3 === 1'b0) begin
      s_out = 0; s_rises = 0; s_mosi = '0;
    end
    if (cs3 === 1'b0) begin
      if (ps3 === 1'b1 && sclk3 === 1'b0 && s_out < 8) begin
        miso3 = s_word[7 - s_out];
        s_out++;
      end
      if (ps3 === 1'b0 && sclk3 === 1'b1) begin
        s_mosi = {s_mosi[6:0], mosi3};
        s_rises++;
      end
    end
    ps3 = sclk3;
    pc3 = cs3;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, edges, rise, pulses, n, r1, r2, f2, falls, hi_cycles;
    logic prev, prev_cs, rv_rise;
    logic [23:0] w1, w2, rd;
    logic [7:0] bits;

    repeat (3) @(posedge clk);
    #1 r0 = 1'b0; r3 = 1'b0; rl = 1'b0;
    @(negedge clk);
    check_eq("rst_cs_l",     32'(cs0),   32'd1);
    check_eq("rst_sclk",     32'(sclk0), 32'd0);
    check_eq("rst_data",     32'(mosi0), 32'd0);
    check_eq("rst_rx_valid", 32'(rxv0),  32'd0);
    check_eq("rst_rx_data",  32'(rxd0),  32'd0);
    check_eq("rst_counter",  32'(cnt0),  32'd0);
    check_eq("rst_busy",     32'(busy0), 32'd0);
    check_eq("rst_tx_ready", 32'(trdy0), 32'd1);
    check_eq("rst_m3_sclk",  32'(sclk3), 32'd1);

    // Mode 0 loopback frame
    td0 = 24'hD73003; tv0 = 1'b1;
    @(posedge clk); #1 tv0 = 1'b0;
    cyc = 1; edges = 0; rise = 0; pulses = 0; prev = sclk0; rv_rise = 1'b0; rd = '0;
    while (cyc < 200 && rise == 0) begin
      @(negedge clk);
      if (cyc == 1) begin
        check_eq("m0_cs_low_c1",   32'(cs0),   32'd0);
        check_eq("m0_first_bit",   32'(mosi0), 32'd1);
        check_eq("m0_ready_low",   32'(trdy0), 32'd0);
      end
      if (sclk0 !== prev) edges++;
      prev = sclk0;
      if (rxv0 === 1'b1) pulses++;
      if (cs0 === 1'b1) begin rise = cyc; rv_rise = rxv0; rd = rxd0; end
      @(posedge clk); #1 cyc++;
    end
    check_eq("m0_cs_rise_cycle", rise, 101);
    check_eq("m0_sclk_edges",    edges, 48);
    check_eq("m0_rxv_at_rise",   32'(rv_rise), 32'd1);
    check_eq("m0_rxv_pulses",    pulses, 1);
    check_eq("m0_rx_data",       32'(rd), 32'h00D73003);
    check_eq("m0_counter_end",   32'(cnt0), 32'd24);
    @(negedge clk);
    check_eq("m0_rxv_one_cycle", 32'(rxv0), 32'd0);
    check_eq("m0_rx_data_hold",  32'(rxd0), 32'h00D73003);

    // Back-to-back words with tx_valid held high
    n = 0;
    while (trdy0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    td0 = 24'h000D73; tv0 = 1'b1;
    @(posedge clk); #1 td0 = 24'h000003;
    cyc = 1; r1 = 0; r2 = 0; f2 = 0; prev_cs = 1'b0; w1 = '0; w2 = '0;
    while (cyc < 400 && r2 == 0) begin
      @(negedge clk);
      if (rxv0 === 1'b1) begin
        if (r1 == 0) w1 = rxd0; else w2 = rxd0;
      end
      if (cs0 === 1'b1 && prev_cs === 1'b0) begin
        if (r1 == 0) r1 = cyc; else r2 = cyc;
      end
      if (cs0 === 1'b0 && prev_cs === 1'b1 && r1 != 0) begin f2 = cyc; tv0 = 1'b0; end
      prev_cs = cs0;
      @(posedge clk); #1 cyc++;
    end
    tv0 = 1'b0;
    check_eq("b2b_first_rise",   r1, 101);
    check_eq("b2b_gap_cycles",   f2 - r1, 4);
    check_eq("b2b_second_len",   r2 - f2, 100);
    check_eq("b2b_word1",        32'(w1), 32'h00000D73);
    check_eq("b2b_word2",        32'(w2), 32'h00000003);

    // Reset in cycle 30 of a frame
    n = 0;
    while (trdy0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    td0 = 24'hFFFFFF; tv0 = 1'b1;
    @(posedge clk); #1 tv0 = 1'b0;
    cyc = 1;
    while (cyc < 30) begin @(posedge clk); #1 cyc++; end
    r0 = 1'b1;
    @(negedge clk);
    check_eq("rst30_counter_before", 32'(cnt0), 32'd7);
    check_eq("rst30_cs_before",      32'(cs0),  32'd0);
    @(posedge clk); #1 r0 = 1'b0;
    @(negedge clk);
    check_eq("rst31_cs_l",     32'(cs0),   32'd1);
    check_eq("rst31_sclk",     32'(sclk0), 32'd0);
    check_eq("rst31_tx_ready", 32'(trdy0), 32'd1);
    check_eq("rst31_busy",     32'(busy0), 32'd0);
    check_eq("rst31_counter",  32'(cnt0),  32'd0);
    check_eq("rst31_rx_data",  32'(rxd0),  32'd0);
    pulses = 0; edges = 0; prev = sclk0;
    repeat (120) begin
      @(negedge clk);
      if (rxv0 === 1'b1) pulses++;
      if (sclk0 !== prev) edges++;
      prev = sclk0;
    end
    check_eq("rst_abort_no_rxv",  pulses, 0);
    check_eq("rst_abort_no_sclk", edges, 0);

    // Mode 3 frame against the slave model
    td3 = 8'hA5; tv3 = 1'b1;
    @(posedge clk); #1 tv3 = 1'b0;
    cyc = 1; rise = 0; rv_rise = 1'b0; bits = '0; prev = 1'b0;
    while (cyc < 100 && rise == 0) begin
      @(negedge clk);
      if (cs3 === 1'b1) begin rise = cyc; rv_rise = rxv3; bits = rxd3; prev = sclk3; end
      @(posedge clk); #1 cyc++;
    end
    check_eq("m3_cs_rise_cycle", rise, 19);
    check_eq("m3_rxv_at_rise",   32'(rv_rise), 32'd1);
    check_eq("m3_rx_data",       32'(bits), 32'h3C);
    check_eq("m3_slave_mosi",    32'(s_mosi), 32'hA5);
    check_eq("m3_slave_rises",   s_rises, 8);
    check_eq("m3_sclk_idle_end", 32'(prev), 32'd1);
    check_eq("m3_counter_end",   32'(cnt3), 32'd8);

    // LSB first with tx_valid pulses while busy
    tdl = 8'h01; tvl = 1'b1;
    @(posedge clk); #1 tvl = 1'b0;
    cyc = 1; rise = 0; pulses = 0; falls = 0; hi_cycles = 0;
    bits = '0; prev = sclkl; prev_cs = 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      tvl = 1'b0;
      if (cyc == 5 || cyc == 12 || cyc == 19) begin tdl = 8'hFF; tvl = 1'b1; end
      if (prev === 1'b0 && sclkl === 1'b1) bits = {mosil, bits[7:1]};
      if (csl === 1'b0 && mosil === 1'b1) hi_cycles++;
      if (csl === 1'b0 && prev_cs === 1'b1) falls++;
      if (csl === 1'b1 && prev_cs === 1'b0) rise = cyc;
      if (rxvl === 1'b1) pulses++;
      prev = sclkl;
      prev_cs = csl;
      @(posedge clk); #1 cyc++;
    end
    tvl = 1'b0;
    check_eq("lsb_sampled_bits", 32'(bits), 32'h01);
    check_eq("lsb_hi_cycles",    hi_cycles, 2);
    check_eq("lsb_frames",       falls, 1);
    check_eq("lsb_rise_cycle",   rise, 19);
    check_eq("lsb_rxv_pulses",   pulses, 1);
    check_eq("lsb_rx_data",      32'(rxdl), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
